// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Purpose  : Byte FIFO plus launch FSM sitting in front of a UART transmitter.
//             The bus side pushes bytes. The FSM pops one byte at a time,
//             presents it on byte_tx with a single-cycle start_tx pulse, and
//             paces the next launch on the UART's done_tx idle flag. The result
//             is back-to-back serial output without per-byte software polling.
//  Ports    : clk       - system clock, rising edge
//             arstn     - asynchronous active-low reset
//             wr_en     - push request
//             wr_data   - byte to push
//             flush     - synchronous clear of FIFO contents
//             full      - FIFO holds DEPTH bytes (registered)
//             level     - bytes stored, 0..DEPTH (registered)
//             overflow  - 1-cycle pulse, push dropped because full
//             busy      - bytes queued or a launch still in progress
//             byte_tx   - byte presented to the UART (registered)
//             start_tx  - 1-cycle launch pulse to the UART
//             done_tx   - UART idle flag
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          arstn,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          flush,
  output logic          full,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic          busy,
  output logic [7:0]    byte_tx,
  output logic          start_tx,
  input  logic          done_tx
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK  = 2'd1,
    S_BUSY = 2'd2
  } state_t;

  localparam logic [AW:0] c_level_last_free = (AW+1)'(DEPTH - 1);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  state_t        r_state;

  logic w_push;
  logic w_pop;

  // full is the registered flag, so a full FIFO rejects a push even when the
  // FSM pops on the same edge. flush wins over both push and pop.
  assign w_push = wr_en & ~full & ~flush;
  assign w_pop  = (r_state == S_IDLE) & (level != '0) & done_tx & ~flush;

  assign busy = (level != '0) | (r_state != S_IDLE);

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy and overflow pulse.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      level    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      // A push squashed by flush is not reported as an overflow.
      overflow <= wr_en & full & ~flush;
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        level    <= '0;
        full     <= 1'b0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        case ({w_push, w_pop})
          2'b10: begin
            level <= level + 1'b1;
            full  <= (level == c_level_last_free);
          end
          2'b01: begin
            level <= level - 1'b1;
            full  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  // Launch FSM. The pop itself is qualified by w_pop so FIFO bookkeeping and
  // the launch always agree on the same edge.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_state  <= S_IDLE;
      start_tx <= 1'b0;
      byte_tx  <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          start_tx <= 1'b0;
          if (w_pop) begin
            byte_tx  <= r_mem[r_rd_ptr];
            start_tx <= 1'b1;
            r_state  <= S_ACK;
          end
        end
        S_ACK: begin
          // Wait for the UART to drop its idle flag; no timeout by design.
          start_tx <= 1'b0;
          if (!done_tx) begin
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          start_tx <= 1'b0;
          if (done_tx) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          start_tx <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
